uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel receive path of the UART system. Oversamples rx at 16x
//  using sample_tick from the shared baud rate generator. Recovers DBITS data
//  bits (LSB first), an optional parity bit and the stop bit(s). Delivers each
//  word with a one-cycle rx_done strobe for writing into the RX FIFO.
// PARAMETERS
//  DBITS    8   data bits per frame; legal range 5..8
//  SB_TICK  16  stop-bit length in ticks; 16 = 1 stop bit, 24 = 1.5, 32 = 2 (max 32)
//  PARITY   0   0 = none, 1 = even, 2 = odd
// PORTS
//  clk_100MHz   in   1      system clock, 100 MHz
//  reset        in   1      asynchronous, active-high
//  rx           in   1      serial line; asynchronous, idles high
//  sample_tick  in   1      1-clk pulse at 16x baud (period >= 2 clk)
//  data_out     out  DBITS  last received word
//  rx_done      out  1      1-clk strobe: data_out and error flags updated
//  parity_err   out  1      parity mismatch on last frame (0 when PARITY=0)
//  frame_err    out  1      stop bit sampled low on last frame
// BEHAVIOUR
//  - Reset (asynchronous, active-high, clock clk_100MHz) clears everything:
//    data_out=0, rx_done=0, parity_err=0, frame_err=0; state=IDLE; counters=0.
//    Synchroniser flops reset to 1. Reset mid-frame abandons the frame with no
//    rx_done. The first edge after release behaves as in IDLE.
//  - rx passes through a 2-FF synchroniser (rx_s) before any use.
//  - Tick counter is 5 bits wide; bit counter is 3 bits wide. Both advance only
//    on sample_tick.
//  - FSM states: IDLE, START, DATA, PARITY, STOP.
//  - IDLE: falling edge of rx_s (previous 1, now 0) -> START, tick=0.
//    Entry is edge-triggered, so a held-low line (break) never retriggers.
//  - START: on the tick with tick==7 (mid start bit):
//      rx_s==0 -> DATA, tick=0, nbits=0
//      rx_s==1 -> glitch; return to IDLE with no strobe
//  - DATA: on the tick with tick==15, shift in rx_s at the MSB:
//    shreg={rx_s,shreg[DBITS-1:1]}; tick=0.
//    After nbits==DBITS-1, go to PARITY if PARITY!=0, else to STOP.
//  - PARITY: on tick==15, capture rx_s into par_bit, then go to STOP, tick=0.
//  - STOP: on the tick with tick==SB_TICK-1, register the following, then go to IDLE:
//      data_out=shreg
//      frame_err=~rx_s
//      parity_err=(PARITY==1)? ^{shreg,par_bit} : (PARITY==2)? ~^{shreg,par_bit} : 0
//      rx_done=1 for exactly one clk
//  - rx_done is registered. It rises on the clk edge that consumes the final
//    STOP tick. data_out and both error flags change only on that same edge
//    and hold until the next frame completes.
//  - A frame with frame_err or parity_err still strobes rx_done. Data is
//    delivered and the consumer decides whether to drop it.
//  - Back-to-back frames: a start edge arriving in the first clk after STOP
//    exits is accepted, so no idle gap is needed beyond the stop bit.
//  - Clocks without sample_tick hold state. Tick counter wraps only via the
//    explicit resets above.
// TESTING (bench drives sample_tick every 4 clk; 1 bit = 16 ticks = 64 clk)
//  1. Default params, send 0xA5 with 1 stop bit -> exactly one rx_done;
//     data_out=0xA5, frame_err=0, parity_err=0.
//  2. Back-to-back frames 0x00, 0xFF, 0x3C with no gaps -> three rx_done
//     strobes, values in order, no errors.
//  3. rx low pulse of 5 ticks, then high -> no rx_done, FSM back in IDLE;
//     a following 0x81 frame is received correctly.
//  4. 0x55 with stop bit driven low, line held low 40 bit-times, then high,
//     then 0x12 -> first rx_done has frame_err=1 and data_out=0x55; no
//     spurious frames during the break; 0x12 is received clean.
//  5. PARITY=1, DBITS=7: send 0x35 with correct parity bit 0, then with
//     parity bit 1 -> parity_err=0, then parity_err=1; data_out=0x35 both times.
//  6. Assert reset mid-DATA of frame 0xC3 -> outputs all 0 immediately,
//     no rx_done; a fresh 0x7E frame after release gives data_out=0x7E.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receive path: 16x oversampled start/data/parity/stop recovery.
// Delivers each completed frame with a single-cycle rx_done strobe.
module uart_receiver #(
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             rx,
  input  logic             sample_tick,
  output logic [DBITS-1:0] data_out,
  output logic             rx_done,
  output logic             parity_err,
  output logic             frame_err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [1:0] PMODE     = 2'(PARITY);
  localparam logic [4:0] TICK_MID  = 5'd7;
  localparam logic [4:0] TICK_LAST = 5'd15;
  localparam logic [4:0] TICK_STOP = 5'(SB_TICK - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DBITS - 1);

  // Even parity flags an odd number of ones across word+parity; odd parity the reverse.
  function automatic logic parity_error(input logic [DBITS-1:0] word, input logic pbit);
    logic result;
    case (PMODE)
      2'd1:    result = ^{word, pbit};
      2'd2:    result = ~^{word, pbit};
      default: result = 1'b0;
    endcase
    return result;
  endfunction

  logic             sync_meta;
  logic             rx_s;
  logic             rx_prev;
  state_t           state;
  logic [4:0]       tick;
  logic [2:0]       nbits;
  logic [DBITS-1:0] shreg;
  logic             par_bit;

  // Two-flop synchroniser plus one delayed copy for start-edge detection.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
    end else begin
      sync_meta <= rx;
      rx_s      <= sync_meta;
      rx_prev   <= rx_s;
    end
  end

  // Frame FSM with registered word, error flags and done strobe.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      tick       <= 5'd0;
      nbits      <= 3'd0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Edge-triggered entry: a line held low (break) never restarts a frame.
          if (rx_prev && !rx_s) begin
            state <= ST_START;
            tick  <= 5'd0;
          end
        end

        ST_START: begin
          if (sample_tick) begin
            if (tick == TICK_MID) begin
              tick <= 5'd0;
              if (!rx_s) begin
                state <= ST_DATA;
                nbits <= 3'd0;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              tick <= tick + 5'd1;
            end
          end
        end

        ST_DATA: begin
          if (sample_tick) begin
            if (tick == TICK_LAST) begin
              tick  <= 5'd0;
              shreg <= {rx_s, shreg[DBITS-1:1]};
              if (nbits == LAST_BIT) begin
                state <= (PMODE != 2'd0) ? ST_PARITY : ST_STOP;
              end else begin
                nbits <= nbits + 3'd1;
              end
            end else begin
              tick <= tick + 5'd1;
            end
          end
        end

        ST_PARITY: begin
          if (sample_tick) begin
            if (tick == TICK_LAST) begin
              tick    <= 5'd0;
              par_bit <= rx_s;
              state   <= ST_STOP;
            end else begin
              tick <= tick + 5'd1;
            end
          end
        end

        ST_STOP: begin
          if (sample_tick) begin
            if (tick == TICK_STOP) begin
              // Errored frames are still delivered; the consumer decides.
              data_out   <= shreg;
              frame_err  <= ~rx_s;
              parity_err <= parity_error(shreg, par_bit);
              rx_done    <= 1'b1;
              tick       <= 5'd0;
              state      <= ST_IDLE;
            end else begin
              tick <= tick + 5'd1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          tick  <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: default-parameter instance plus a 7-bit even-parity instance.
module tb_uart_receiver;

  logic       clk_100MHz;
  logic       reset;
  logic       rx;
  logic       rx_p;
  logic       sample_tick;
  logic [7:0] data_out;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic [6:0] data_out_p;
  logic       rx_done_p;
  logic       parity_err_p;
  logic       frame_err_p;

  int checks = 0;
  int errors = 0;
  int tcnt   = 0;

  logic [9:0] q0[$];
  logic [9:0] q1[$];

  uart_receiver dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .rx         (rx),
    .sample_tick(sample_tick),
    .data_out   (data_out),
    .rx_done    (rx_done),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  uart_receiver #(.DBITS(7), .SB_TICK(16), .PARITY(1)) dut_p (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .rx         (rx_p),
    .sample_tick(sample_tick),
    .data_out   (data_out_p),
    .rx_done    (rx_done_p),
    .parity_err (parity_err_p),
    .frame_err  (frame_err_p)
  );

  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  // One-clock tick every fourth clock.
  initial begin
    sample_tick = 1'b0;
    forever begin
      @(negedge clk_100MHz);
      tcnt = (tcnt + 1) % 4;
      sample_tick = (tcnt == 0);
    end
  end

  // Record every strobe as {parity_err, frame_err, data}.
  always @(negedge clk_100MHz) begin
    if (rx_done)   q0.push_back({parity_err, frame_err, data_out});
    if (rx_done_p) q1.push_back({parity_err_p, frame_err_p, 1'b0, data_out_p});
  end

  task automatic drive_bit(input bit sel, input logic b);
    if (sel) rx_p = b;
    else     rx   = b;
    repeat (64) @(negedge clk_100MHz);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input int nb,
                            input bit par_en, input logic pb, input logic stop);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(sel, d[i]);
    if (par_en) drive_bit(sel, pb);
    drive_bit(sel, stop);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_100MHz);
    #1;
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    checks++;
    if (rx_done !== 1'b0) begin errors++; $display("FAIL reset_rx_done: got %b want 0", rx_done); end
    checks++;
    if ({parity_err, frame_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {parity_err, frame_err}); end
    checks++;
    if (data_out_p !== 7'h00) begin errors++; $display("FAIL reset_data_out_p: got %h want 00", data_out_p); end
    @(negedge clk_100MHz);
    reset = 1'b0;
    repeat (20) @(negedge clk_100MHz);
    checks++;
    if (q0.size() != 0) begin errors++; $display("FAIL reset_no_strobe: got %0d strobes want 0", q0.size()); end
  endtask

  task automatic test_single;
    q0.delete();
    send_frame(1'b0, 8'hA5, 8, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk_100MHz);
    checks++;
    if (q0.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", q0.size()); end
    if (q0.size() >= 1) begin
      checks++;
      if (q0[0] !== 10'h0A5) begin errors++; $display("FAIL single_frame: got %h want 0a5", q0[0]); end
    end
    checks++;
    if ({parity_err, frame_err, data_out} !== 10'h0A5) begin
      errors++; $display("FAIL single_hold: got %h want 0a5", {parity_err, frame_err, data_out});
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp [3];
    exp[0] = 10'h000; exp[1] = 10'h0FF; exp[2] = 10'h03C;
    q0.delete();
    send_frame(1'b0, 8'h00, 8, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'hFF, 8, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h3C, 8, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk_100MHz);
    checks++;
    if (q0.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", q0.size()); end
    for (int i = 0; i < 3 && i < q0.size(); i++) begin
      checks++;
      if (q0[i] !== exp[i]) begin errors++; $display("FAIL b2b_frame%0d: got %h want %h", i, q0[i], exp[i]); end
    end
  endtask

  task automatic test_glitch;
    q0.delete();
    rx = 1'b0;
    repeat (20) @(negedge clk_100MHz);
    rx = 1'b1;
    repeat (200) @(negedge clk_100MHz);
    checks++;
    if (q0.size() != 0) begin errors++; $display("FAIL glitch_no_strobe: got %0d want 0", q0.size()); end
    send_frame(1'b0, 8'h81, 8, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk_100MHz);
    checks++;
    if (q0.size() != 1) begin errors++; $display("FAIL glitch_follow_count: got %0d want 1", q0.size()); end
    if (q0.size() >= 1) begin
      checks++;
      if (q0[0] !== 10'h081) begin errors++; $display("FAIL glitch_follow_frame: got %h want 081", q0[0]); end
    end
  endtask

  task automatic test_break;
    q0.delete();
    send_frame(1'b0, 8'h55, 8, 1'b0, 1'b0, 1'b0);
    repeat (40 * 64) @(negedge clk_100MHz);
    rx = 1'b1;
    repeat (64) @(negedge clk_100MHz);
    checks++;
    if (q0.size() != 1) begin errors++; $display("FAIL break_count: got %0d want 1", q0.size()); end
    if (q0.size() >= 1) begin
      checks++;
      if (q0[0] !== 10'h155) begin errors++; $display("FAIL break_frame_err: got %h want 155", q0[0]); end
    end
    send_frame(1'b0, 8'h12, 8, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk_100MHz);
    checks++;
    if (q0.size() != 2) begin errors++; $display("FAIL break_follow_count: got %0d want 2", q0.size()); end
    if (q0.size() >= 2) begin
      checks++;
      if (q0[1] !== 10'h012) begin errors++; $display("FAIL break_follow_frame: got %h want 012", q0[1]); end
    end
  endtask

  task automatic test_parity;
    q1.delete();
    send_frame(1'b1, 8'h35, 7, 1'b1, 1'b0, 1'b1);
    send_frame(1'b1, 8'h35, 7, 1'b1, 1'b1, 1'b1);
    repeat (20) @(negedge clk_100MHz);
    checks++;
    if (q1.size() != 2) begin errors++; $display("FAIL parity_count: got %0d want 2", q1.size()); end
    if (q1.size() >= 2) begin
      checks++;
      if (q1[0] !== 10'h035) begin errors++; $display("FAIL parity_good: got %h want 035", q1[0]); end
      checks++;
      if (q1[1] !== 10'h235) begin errors++; $display("FAIL parity_bad: got %h want 235", q1[1]); end
    end
  endtask

  task automatic test_reset_mid;
    q0.delete();
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL midreset_data_out: got %h want 00", data_out); end
    checks++;
    if ({rx_done, parity_err, frame_err} !== 3'b000) begin
      errors++; $display("FAIL midreset_flags: got %b want 000", {rx_done, parity_err, frame_err});
    end
    checks++;
    if (parity_err_p !== 1'b0) begin errors++; $display("FAIL midreset_parity_p: got %b want 0", parity_err_p); end
    rx = 1'b1;
    repeat (10) @(negedge clk_100MHz);
    reset = 1'b0;
    repeat (200) @(negedge clk_100MHz);
    checks++;
    if (q0.size() != 0) begin errors++; $display("FAIL midreset_no_strobe: got %0d want 0", q0.size()); end
    send_frame(1'b0, 8'h7E, 8, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk_100MHz);
    checks++;
    if (q0.size() != 1) begin errors++; $display("FAIL midreset_follow_count: got %0d want 1", q0.size()); end
    if (q0.size() >= 1) begin
      checks++;
      if (q0[0] !== 10'h07E) begin errors++; $display("FAIL midreset_follow_frame: got %h want 07e", q0[0]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    rx_p  = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_parity();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
